// File: rtl/delta_adc_pkg.sv
// Shared constants and width helper for the DeltaADC digital back-end.
package delta_adc_pkg;

  localparam int OSR_LOG2_DEF  = 6;
  localparam int OUT_W         = 8;
  localparam int SETTLE_DECIMS = 2;

  // Sinc2 output spans 0..OSR^2, which needs 2*log2(OSR)+1 bits.
  function automatic int cic_w(input int osr_log2);
    return 2 * osr_log2 + 1;
  endfunction

endpackage

// File: rtl/delta_adc_cic2.sv
// Two-stage CIC (sinc2) decimator: integrators at the modulator rate,
// combs evaluated once per OSR cycles. All arithmetic wraps modulo 2^W.
module delta_adc_cic2
  import delta_adc_pkg::*;
#(
  parameter int OSR_LOG2 = OSR_LOG2_DEF,
  parameter int W        = cic_w(OSR_LOG2)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         x,
  output logic [W-1:0] y,
  output logic         y_strobe
);

  logic [W-1:0]        i1;
  logic [W-1:0]        i2;
  logic [W-1:0]        i2_d;
  logic [W-1:0]        c1;
  logic [W-1:0]        c1_d;
  logic [OSR_LOG2-1:0] dcnt;

  // Decimation point: last cycle of the OSR-long frame.
  assign y_strobe = en && (dcnt == '1);
  assign c1       = i2 - i2_d;
  assign y        = c1 - c1_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i1   <= '0;
      i2   <= '0;
      i2_d <= '0;
      c1_d <= '0;
      dcnt <= '0;
    end else if (!en) begin
      i1   <= '0;
      i2   <= '0;
      i2_d <= '0;
      c1_d <= '0;
      dcnt <= '0;
    end else begin
      i1   <= i1 + {{(W-1){1'b0}}, x};
      i2   <= i2 + i1;
      dcnt <= dcnt + 1'b1;
      if (y_strobe) begin
        i2_d <= i2;
        c1_d <= c1;
      end
    end
  end

endmodule

// File: rtl/delta_adc_decimator.sv
// DeltaADC back-end: comparator synchroniser/feedback, sinc2 decimation,
// settle gating and 8-bit mapping. Optional sticky sat_flag via ADC_SAT_FLAG_EN.
module delta_adc_decimator
  import delta_adc_pkg::*;
#(
  parameter int OSR_LOG2 = OSR_LOG2_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             cmp_in,
  output logic             fb_out,
  output logic [OUT_W-1:0] sample,
  output logic             sample_valid
`ifdef ADC_SAT_FLAG_EN
  ,
  output logic             sat_flag
`endif
);

  localparam int W = cic_w(OSR_LOG2);
  localparam logic [W-1:0] Y_FULL = W'(1) << (2 * OSR_LOG2);

  logic             s1;
  logic             s2;
  logic [W-1:0]     y;
  logic             y_strobe;
  logic [1:0]       settle_cnt;
  logic             settled;
  logic             y_sat;
  logic [OUT_W-1:0] mapped;

  // Synchroniser runs regardless of en so the analog loop stays closed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= cmp_in;
      s2 <= s1;
    end
  end

  assign fb_out = s2;

  delta_adc_cic2 #(
    .OSR_LOG2 (OSR_LOG2),
    .W        (W)
  ) u_cic (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .x        (s2),
    .y        (y),
    .y_strobe (y_strobe)
  );

  assign settled = (settle_cnt == 2'(SETTLE_DECIMS));
  assign y_sat   = (y >= Y_FULL);
  assign mapped  = y_sat ? {OUT_W{1'b1}} : OUT_W'(y >> (W - 1 - OUT_W));

  // Output contract: sample_valid is a single-cycle strobe with no ready;
  // the consumer must capture sample on it. sample then holds for OSR-1 cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      settle_cnt   <= '0;
      sample       <= '0;
      sample_valid <= 1'b0;
    end else if (!en) begin
      settle_cnt   <= '0;
      sample_valid <= 1'b0;
    end else begin
      sample_valid <= y_strobe && settled;
      if (y_strobe) begin
        if (settled) sample <= mapped;
        else         settle_cnt <= settle_cnt + 1'b1;
      end
    end
  end

`ifdef ADC_SAT_FLAG_EN
  // Flags both rails: clamped full scale and an all-zero result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_flag <= 1'b0;
    end else if (!en) begin
      sat_flag <= 1'b0;
    end else if (y_strobe && settled && (y_sat || (y == '0))) begin
      sat_flag <= 1'b1;
    end
  end
`endif

endmodule

// File: doc/delta_adc_decimator.md
Name: delta_adc_decimator

Overview:
- Digital back-end of the DeltaADC TinyTapeout design.
- Sits between the external comparator/RC integrator and the top-level `uo_out` pins.
- Synchronises the 1-bit comparator decision and returns it as the feedback bit that closes the first-order delta-sigma loop.
- Decimates the bitstream with a sinc2 (2-stage CIC) filter into 8-bit samples, each with a one-cycle valid strobe.

Parameters:
- OSR_LOG2, 6, log2 of oversampling ratio (OSR=64); legal range 4..10.
- OUT_W, 8, output sample width; fixed at 8 for the pin budget.

Ports:
- clk  in  1  system clock; also the modulator sampling clock
- rst_n  in  1  asynchronous active-low reset
- en  in  1  conversion enable (from ui_in[0])
- cmp_in  in  1  raw comparator output, asynchronous to clk
- fb_out  out  1  feedback bit to the external RC DAC
- sample  out  OUT_W  latest decimated sample, unsigned
- sample_valid  out  1  one-cycle pulse when `sample` updates

Behaviour:
- Reset (async assert, sync release): all flops 0. Specifically:
  - fb_out=0, sample=0, sample_valid=0.
  - Both synchroniser stages, both integrators, both comb delays, the decimation counter and the settle counter are 0.
- Synchroniser: cmp_in passes through 2 flops (s1→s2). fb_out = s2, so fb_out lags cmp_in by 2 cycles. The CIC input bit is x = s2.
- The synchroniser and fb_out run whenever out of reset, regardless of en, so the analog loop stays closed.
- Width W = 2*OSR_LOG2+1 (13 at default). All integrator/comb arithmetic is unsigned modulo 2^W; wrap-around is intended and must not be saturated.
- en=1, every cycle:
  - i1 <= i1 + x
  - i2 <= i2 + i1
  - dcnt <= dcnt+1, wrapping after OSR-1
- Decimation point is the cycle where dcnt==OSR-1:
  - c1 = i2 - i2_d; i2_d <= i2
  - y = c1 - c1_d; c1_d <= c1
  - y range is 0..OSR^2.
- Output mapping:
  - y >= OSR^2 (bit 2*OSR_LOG2 set) → sample=8'hFF (saturate).
  - Otherwise sample = y[2*OSR_LOG2-1 -: 8].
- Registration and latency: sample and sample_valid are registered. sample_valid=1 in the cycle after the decimation point; sample_valid is never asserted on two consecutive cycles.
- Settling: after en rises (or reset releases with en=1), the first 2 decimation points update the comb delays only. No sample_valid and no sample change until the 3rd decimation point.
- en=0:
  - Next cycle clears i1, i2, i2_d, c1_d, dcnt and the settle counter; sample_valid=0.
  - sample holds its last value.
  - Re-asserting en restarts settling from scratch.
- en falling in the same cycle as a decimation point: that decimation is discarded; no sample_valid.
- Reset mid-conversion: immediate async clear as above; sample returns to 0.
- No back-pressure: the consumer must take sample on sample_valid. sample is stable for OSR-1 cycles after each strobe.

Optional Feature:
- Macro ADC_SAT_FLAG_EN.
- Defined:
  - Adds output port `sat_flag` (1 bit, reset 0).
  - sat_flag is set in the cycle sample_valid asserts with a saturated (8'hFF-clamped, y>=OSR^2) value, or when y==0.
  - It is sticky until en=0 or reset.
  - The top level maps it to uo_out bit via uio_out[0] with uio_oe[0]=1.
- Not defined: port absent, no saturation-detect logic; sample behaviour identical in both builds.

Decomposition:
- Package delta_adc_pkg holds:
  - OSR_LOG2_DEF and OUT_W constants
  - function cic_w(osr_log2) returning 2*osr_log2+1
  - SETTLE_DECIMS=2 constant
- Sub-module delta_adc_cic2 (integrators, decimation counter, combs; outputs raw y and y_strobe).
- Top block keeps the synchroniser, settle logic, output mapping/saturation and the optional flag.

Test Plan:
- cmp_in held 1, en=1 from reset, OSR=64:
  - fb_out=1 from cycle 3.
  - First sample_valid at cycle ~193 (3rd decimation+1), sample=8'hFF.
  - Later strobes exactly every 64 cycles, always 8'hFF.
  - sat_flag=1 when enabled.
- cmp_in held 0 → every sample=8'h00 after settling; sat_flag=1 when ADC_SAT_FLAG_EN is defined (the y==0 case).
- cmp_in toggling every cycle → y=2048, sample=8'h80 ±1 LSB after settling; sat_flag stays 0.
- cmp_in pattern with 3 ones per 4 cycles → sample=8'hC0 ±1.
- en dropped mid-frame for 10 cycles, then re-raised:
  - no strobe while low; sample holds its last value.
  - After re-raise, first strobe only after 3 full decimation periods.
- rst_n pulsed low mid-conversion, asynchronously (not clock-aligned) → sample, sample_valid and fb_out go to 0 immediately; after release, behaviour repeats the first scenario.
